// File: rtl/cacheline_adaptor_pkg.sv
// rtl/cacheline_adaptor_pkg.sv - shared constants and state type for the cache line / memory burst adaptor
package cacheline_adaptor_pkg;

  localparam int CL_BLOCK_SIZE  = 256;
  localparam int CL_BURST_WIDTH = 64;
  localparam int CL_ADDR_WIDTH  = 32;
  localparam int CL_BEATS       = CL_BLOCK_SIZE / CL_BURST_WIDTH;
  localparam int CL_OFFSET_BITS = $clog2(CL_BLOCK_SIZE / 8);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    WB   = 2'd2,
    DONE = 2'd3
  } adaptor_state_t;

endpackage

// File: rtl/cacheline_adaptor.sv
// rtl/cacheline_adaptor.sv - assembles memory beats into cache lines (fill) and serializes evicted lines (write-back)
module cacheline_adaptor
  import cacheline_adaptor_pkg::*;
#(
  parameter int BLOCK_SIZE  = CL_BLOCK_SIZE,
  parameter int BURST_WIDTH = CL_BURST_WIDTH,
  parameter int ADDR_WIDTH  = CL_ADDR_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [BLOCK_SIZE-1:0]  line_i,
  output logic [BLOCK_SIZE-1:0]  line_o,
  input  logic [ADDR_WIDTH-1:0]  address_i,
  input  logic                   read_i,
  input  logic                   write_i,
  output logic                   resp_o,
  input  logic [BURST_WIDTH-1:0] burst_i,
  output logic [BURST_WIDTH-1:0] burst_o,
  output logic [ADDR_WIDTH-1:0]  address_o,
  output logic                   read_o,
  output logic                   write_o,
  input  logic                   resp_i
);

  localparam int BEATS       = BLOCK_SIZE / BURST_WIDTH;
  localparam int OFFSET_BITS = $clog2(BLOCK_SIZE / 8);
  localparam int CNT_W       = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  adaptor_state_t         state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [BLOCK_SIZE-1:0]  buf_q, buf_d;
  logic [BLOCK_SIZE-1:0]  line_q, line_d;
  logic [BURST_WIDTH-1:0] burst_q, burst_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic                   read_q, read_d;
  logic                   write_q, write_d;
  logic                   resp_q, resp_d;
  logic [ADDR_WIDTH-1:0]  aligned_addr;

  assign aligned_addr = {address_i[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};

  // buf_q is shared: fill assembles into it, write-back serializes out of it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    line_d  = line_q;
    burst_d = burst_q;
    addr_d  = addr_q;
    read_d  = read_q;
    write_d = write_q;
    resp_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (write_i) begin
          state_d = WB;
          cnt_d   = '0;
          buf_d   = line_i;
          burst_d = line_i[BURST_WIDTH-1:0];
          addr_d  = aligned_addr;
          write_d = 1'b1;
        end else if (read_i) begin
          state_d = FILL;
          cnt_d   = '0;
          addr_d  = aligned_addr;
          read_d  = 1'b1;
        end
      end
      FILL: begin
        if (resp_i) begin
          buf_d[int'(cnt_q)*BURST_WIDTH +: BURST_WIDTH] = burst_i;
          if (cnt_q == LAST_BEAT) begin
            state_d = DONE;
            line_d  = buf_d;
            read_d  = 1'b0;
            resp_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      WB: begin
        if (resp_i) begin
          if (cnt_q == LAST_BEAT) begin
            state_d = DONE;
            write_d = 1'b0;
            resp_d  = 1'b1;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            burst_d = buf_q[int'(cnt_d)*BURST_WIDTH +: BURST_WIDTH];
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      buf_q   <= '0;
      line_q  <= '0;
      burst_q <= '0;
      addr_q  <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      resp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      line_q  <= line_d;
      burst_q <= burst_d;
      addr_q  <= addr_d;
      read_q  <= read_d;
      write_q <= write_d;
      resp_q  <= resp_d;
    end
  end

  assign line_o    = line_q;
  assign burst_o   = burst_q;
  assign address_o = addr_q;
  assign read_o    = read_q;
  assign write_o   = write_q;
  assign resp_o    = resp_q;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// tb/tb_cacheline_adaptor.sv - directed/randomized self-checking bench for cacheline_adaptor
module tb_cacheline_adaptor;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  logic         resp_o;
  logic [63:0]  burst_i;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i;

  int checks = 0;
  int errors = 0;
  logic [255:0] last_line = '0;

  cacheline_adaptor dut (
    .clk       (clk),
    .rst       (rst),
    .line_i    (line_i),
    .line_o    (line_o),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .resp_o    (resp_o),
    .burst_i   (burst_i),
    .burst_o   (burst_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .resp_i    (resp_i)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  // Model: a line is four 64-bit beats, beat k occupies bits [64k+63:64k].
  // Memory address is the request address rounded down to a 32-byte line.
  task automatic do_fill(input logic [31:0] addr, input logic [255:0] data,
                         input int maxstall, input bit req_pending);
    logic [31:0] exp_addr;
    exp_addr = addr & ~32'h1F;
    if (!req_pending) begin
      read_i    = 1'b1;
      address_i = addr;
      step();
    end
    read_i    = 1'b0;
    address_i = $urandom;
    for (int k = 0; k < 4; k++) begin
      int n;
      n = $urandom_range(0, maxstall);
      for (int s = 0; s < n; s++) begin
        resp_i  = 1'b0;
        burst_i = {$urandom, $urandom};
        chk("fill_stall_read_o", read_o, 1'b1);
        chk("fill_stall_resp_o", resp_o, 1'b0);
        step();
      end
      resp_i  = 1'b1;
      burst_i = data[k*64 +: 64];
      chk("fill_read_o", read_o, 1'b1);
      chk("fill_write_o", write_o, 1'b0);
      chk("fill_address_o", address_o, exp_addr);
      chk("fill_resp_o_early", resp_o, 1'b0);
      step();
    end
    resp_i  = 1'b0;
    burst_i = {$urandom, $urandom};
    chk("fill_done_resp_o", resp_o, 1'b1);
    chk("fill_done_read_o", read_o, 1'b0);
    chk("fill_line_o", line_o, data);
    step();
    chk("fill_after_resp_o", resp_o, 1'b0);
    chk("fill_line_o_held", line_o, data);
    last_line = data;
  endtask

  // Ends in the DONE cycle; caller decides what happens next.
  task automatic do_wb(input logic [31:0] addr, input logic [255:0] data, input int maxstall,
                       input bit also_read, input bit toggle_read);
    logic [31:0] exp_addr;
    exp_addr  = addr & ~32'h1F;
    write_i   = 1'b1;
    read_i    = also_read;
    line_i    = data;
    address_i = addr;
    step();
    write_i   = 1'b0;
    read_i    = 1'b0;
    line_i    = rand_line();
    address_i = $urandom;
    for (int k = 0; k < 4; k++) begin
      int n;
      n = $urandom_range(0, maxstall);
      for (int s = 0; s < n; s++) begin
        resp_i = 1'b0;
        if (toggle_read) read_i = 1'($urandom);
        chk("wb_stall_burst_o", burst_o, data[k*64 +: 64]);
        chk("wb_stall_write_o", write_o, 1'b1);
        step();
      end
      resp_i = 1'b1;
      if (toggle_read) read_i = 1'($urandom);
      chk("wb_burst_o", burst_o, data[k*64 +: 64]);
      chk("wb_write_o", write_o, 1'b1);
      chk("wb_read_o", read_o, 1'b0);
      chk("wb_address_o", address_o, exp_addr);
      chk("wb_resp_o_early", resp_o, 1'b0);
      step();
    end
    resp_i = 1'b0;
    read_i = 1'b0;
    chk("wb_done_resp_o", resp_o, 1'b1);
    chk("wb_done_write_o", write_o, 1'b0);
    chk("wb_done_read_o", read_o, 1'b0);
  endtask

  initial begin
    logic [255:0] d;
    rst = 1'b1; line_i = '0; address_i = '0; read_i = 1'b0; write_i = 1'b0;
    burst_i = '0; resp_i = 1'b0;
    step();
    step();
    chk("rst_line_o", line_o, '0);
    chk("rst_burst_o", burst_o, '0);
    chk("rst_address_o", address_o, '0);
    chk("rst_read_o", read_o, 1'b0);
    chk("rst_write_o", write_o, 1'b0);
    chk("rst_resp_o", resp_o, 1'b0);
    rst = 1'b0;
    step();

    // zero-wait fill with fixed beats; resp_o lands at t+5
    d = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
         64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    read_i = 1'b1; address_i = 32'h0000_1234;
    step();
    chk("dir_address_o", address_o, 32'h0000_1220);
    do_fill(32'h0000_1234, d, 0, 1'b1);

    // write-back with stalls
    do_wb($urandom, rand_line(), 2, 1'b0, 1'b0);
    step();
    chk("wb_after_resp_o", resp_o, 1'b0);

    // simultaneous read and write: write wins, no fill follows
    do_wb($urandom, rand_line(), 1, 1'b1, 1'b0);
    step();
    chk("sim_idle_read_o", read_o, 1'b0);
    step();
    chk("sim_no_fill_read_o", read_o, 1'b0);

    // reset mid-fill after two beats
    read_i = 1'b1; address_i = 32'hABCD_EF7F;
    step();
    read_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      resp_i = 1'b1; burst_i = {$urandom, $urandom};
      step();
    end
    resp_i = 1'b0;
    chk("pre_rst_line_o", line_o, last_line);
    rst = 1'b1;
    step();
    chk("midrst_read_o", read_o, 1'b0);
    chk("midrst_line_o", line_o, '0);
    chk("midrst_address_o", address_o, '0);
    chk("midrst_resp_o", resp_o, 1'b0);
    rst = 1'b0;
    step();
    chk("postrst_read_o", read_o, 1'b0);
    do_fill($urandom, rand_line(), 2, 1'b0);

    // spurious memory strobes in IDLE
    resp_i = 1'b1; burst_i = {$urandom, $urandom};
    for (int i = 0; i < 3; i++) begin
      step();
      chk("spur_read_o", read_o, 1'b0);
      chk("spur_write_o", write_o, 1'b0);
      chk("spur_resp_o", resp_o, 1'b0);
    end
    resp_i = 1'b0;

    // read_i toggling during write-back
    do_wb($urandom, rand_line(), 2, 1'b0, 1'b1);
    step();
    chk("tog_after_resp_o", resp_o, 1'b0);
    chk("tog_after_read_o", read_o, 1'b0);

    // back-to-back: read_i raised in DONE is taken the following IDLE cycle
    do_wb($urandom, rand_line(), 0, 1'b0, 1'b0);
    read_i = 1'b1; address_i = 32'h0000_5A5A;
    step();
    chk("b2b_idle_read_o", read_o, 1'b0);
    chk("b2b_idle_resp_o", resp_o, 1'b0);
    step();
    chk("b2b_fill_read_o", read_o, 1'b1);
    do_fill(32'h0000_5A5A, rand_line(), 1, 1'b1);

    // randomized mix of fills and write-backs
    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        do_fill($urandom, rand_line(), 3, 1'b0);
      end else begin
        do_wb($urandom, rand_line(), 3, 1'b0, 1'b0);
        step();
        chk("mix_wb_after_resp_o", resp_o, 1'b0);
        chk("mix_line_o_held", line_o, last_line);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
